// File: rtl/execute_cycle.sv
// RV32I execute stage: forwarding muxes, ALU, branch/jump resolution, EX/MEM register.
// Latency: PCSrcE/PCTargetE are combinational; M outputs are 1 cycle after E inputs.
// Backpressure: StallM=1 holds every M output; redirect outputs are never gated by the stall.
module execute_cycle #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [31:0]     InstrE,
    input  logic [4:0]      RdE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            jalrE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [1:0]      ResultSrcE,
    input  logic [XLEN-1:0] ResultW,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic            StallM,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RdM,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [2:0]      funct3M
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] jalr_sum;
    logic [2:0]      funct3;
    logic            taken;
    logic            lt_s;
    logic            lt_u;
    logic            eq;
    logic            unused_instr_bits;

    assign funct3            = InstrE[14:12];
    assign unused_instr_bits = ^{InstrE[31:15], InstrE[11:0]};

    // Select 11 is treated like 00 so a stray encoding never injects X.
    always_comb begin
        src_a = RD1_E;
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResultM;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        write_data = RD2_E;
        case (ForwardBE)
            2'b01:   write_data = ResultW;
            2'b10:   write_data = ALUResultM;
            default: write_data = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? ImmExtE : write_data;

    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            3'b000: alu_result = src_a + src_b;
            3'b001: alu_result = src_a - src_b;
            3'b010: alu_result = src_a & src_b;
            3'b011: alu_result = src_a | src_b;
            3'b100: alu_result = src_a ^ src_b;
            3'b101: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'b110: alu_result = src_a << src_b[4:0];
            3'b111: alu_result = src_a >> src_b[4:0];
            default: alu_result = '0;
        endcase
    end

    // Branch compare sees the forwarded rs2, never the immediate.
    assign lt_s = $signed(src_a) < $signed(write_data);
    assign lt_u = src_a < write_data;
    assign eq   = src_a == write_data;

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = eq;
            3'b001:  taken = !eq;
            3'b100:  taken = lt_s;
            3'b101:  taken = !lt_s;
            3'b110:  taken = lt_u;
            3'b111:  taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end

    assign jalr_sum  = src_a + ImmExtE;
    assign PCSrcE    = JumpE | (BranchE & taken);
    assign PCTargetE = jalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + ImmExtE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RdM        <= '0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            funct3M    <= '0;
        end else if (!StallM) begin
            ALUResultM <= alu_result;
            WriteDataM <= write_data;
            PCPlus4M   <= PCPlus4E;
            RdM        <= RdE;
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            funct3M    <= funct3;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed self-checking bench for execute_cycle; inputs change 1ns after the rising edge,
// outputs are sampled at least 1ns after the edge or after the combinational settle.
module tb_execute_cycle;

    logic        clk, rst;
    logic [31:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, InstrE, ResultW;
    logic [4:0]  RdE;
    logic        RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE, StallM;
    logic [2:0]  ALUControlE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;

    int n_cmp = 0;
    int n_err = 0;

    execute_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExtE(ImmExtE), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .InstrE(InstrE), .RdE(RdE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .JumpE(JumpE), .jalrE(jalrE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .ResultSrcE(ResultSrcE),
        .ResultW(ResultW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallM(StallM),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .funct3M(funct3M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RD1_E = 0; RD2_E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0; InstrE = 0; ResultW = 0;
        RdE = 0; RegWriteE = 0; MemWriteE = 0; JumpE = 0; jalrE = 0; BranchE = 0;
        ALUSrcE = 0; StallM = 0; ALUControlE = 0; ResultSrcE = 0; ForwardAE = 0; ForwardBE = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            RD1_E = $urandom; RD2_E = $urandom; ImmExtE = $urandom; PCPlus4E = $urandom;
            InstrE = $urandom; RdE = 5'($urandom); RegWriteE = 1; MemWriteE = 1;
            ResultSrcE = 2'($urandom); ALUControlE = 3'($urandom); StallM = 0;
            step();
        end
        n_cmp++; if (ALUResultM !== 0) begin n_err++; $display("FAIL reset_alu got %h want 0", ALUResultM); end
        n_cmp++; if (WriteDataM !== 0 || PCPlus4M !== 0) begin n_err++; $display("FAIL reset_data got %h/%h want 0/0", WriteDataM, PCPlus4M); end
        n_cmp++; if ({RdM, RegWriteM, MemWriteM, ResultSrcM, funct3M} !== 0) begin n_err++; $display("FAIL reset_ctl got rd=%0d rw=%b mw=%b rs=%b f3=%b want all 0", RdM, RegWriteM, MemWriteM, ResultSrcM, funct3M); end
        idle_inputs();
        rst = 1'b1;
        RD1_E = 5; RD2_E = 7; ALUControlE = 3'b000; ALUSrcE = 0; RdE = 3; RegWriteE = 1;
        step();
        n_cmp++; if (ALUResultM !== 32'd12) begin n_err++; $display("FAIL first_add got %h want %h", ALUResultM, 32'd12); end
        n_cmp++; if (RdM !== 5'd3 || RegWriteM !== 1'b1) begin n_err++; $display("FAIL first_add_ctl got rd=%0d rw=%b want rd=3 rw=1", RdM, RegWriteM); end
    endtask

    task automatic test_forwarding();
        idle_inputs();
        RD1_E = 32'h10; ALUControlE = 3'b000;
        step();
        n_cmp++; if (ALUResultM !== 32'h10) begin n_err++; $display("FAIL fwd_setup got %h want 00000010", ALUResultM); end
        RD1_E = 1; RD2_E = 32'h99; ResultW = 32'h20; ForwardAE = 2'b10; ForwardBE = 2'b01; ALUControlE = 3'b001;
        step();
        n_cmp++; if (ALUResultM !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL fwd_sub got %h want fffffff0", ALUResultM); end
        n_cmp++; if (WriteDataM !== 32'h20) begin n_err++; $display("FAIL fwd_wdata got %h want 00000020", WriteDataM); end
        ForwardAE = 2'b11;
        step();
        n_cmp++; if (ALUResultM !== 32'hFFFF_FFE1) begin n_err++; $display("FAIL fwd_sel11 got %h want ffffffe1", ALUResultM); end
        ForwardAE = 2'b00; ForwardBE = 2'b11; ALUControlE = 3'b000;
        step();
        n_cmp++; if (ALUResultM !== 32'h9A) begin n_err++; $display("FAIL fwd_b11 got %h want 0000009a", ALUResultM); end
    endtask

    task automatic test_branches();
        logic [2:0] f3 [8];
        logic [31:0] b2 [8];
        logic        br [8];
        logic        exp_src [8];
        f3 = '{3'b100, 3'b110, 3'b000, 3'b010, 3'b001, 3'b101, 3'b111, 3'b100};
        b2 = '{32'h1, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h1};
        br = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_src = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        idle_inputs();
        RD1_E = 32'hFFFF_FFFF; PCE = 32'h100; ImmExtE = 32'h20; ALUSrcE = 1;
        for (int i = 0; i < 8; i++) begin
            RD2_E = b2[i]; BranchE = br[i]; InstrE = 32'h0;
            InstrE[14:12] = f3[i];
            #2;
            n_cmp++; if (PCSrcE !== exp_src[i]) begin n_err++; $display("FAIL branch_%0d f3=%b got %b want %b", i, f3[i], PCSrcE, exp_src[i]); end
        end
        n_cmp++; if (PCTargetE !== 32'h120) begin n_err++; $display("FAIL branch_target got %h want 00000120", PCTargetE); end
    endtask

    task automatic test_jalr();
        idle_inputs();
        RD1_E = 32'h203; ImmExtE = 4; jalrE = 1; JumpE = 1; PCE = 32'h500; PCPlus4E = 32'h44;
        ResultSrcE = 2'b10; ALUSrcE = 1; RegWriteE = 1; RdE = 1;
        #2;
        n_cmp++; if (PCTargetE !== 32'h206) begin n_err++; $display("FAIL jalr_target got %h want 00000206", PCTargetE); end
        n_cmp++; if (PCSrcE !== 1'b1) begin n_err++; $display("FAIL jalr_pcsrc got %b want 1", PCSrcE); end
        step();
        n_cmp++; if (PCPlus4M !== 32'h44 || ResultSrcM !== 2'b10) begin n_err++; $display("FAIL jalr_m got pc4=%h rs=%b want 00000044/10", PCPlus4M, ResultSrcM); end
    endtask

    task automatic test_alu_ops();
        logic [2:0]  op [8];
        logic [31:0] a [8];
        logic [31:0] b [8];
        logic [31:0] exp_res [8];
        op      = '{3'b101, 3'b110, 3'b111, 3'b100, 3'b000, 3'b010, 3'b011, 3'b101};
        a       = '{32'hFFFF_FFFD, 32'h1, 32'h8000_0000, 32'hF0, 32'hFFFF_FFFF, 32'hF0F0, 32'hF0F0, 32'h2};
        b       = '{32'h2, 32'h25, 32'd31, 32'hFF, 32'h1, 32'hFF00, 32'h0F0F, 32'hFFFF_FFFD};
        exp_res = '{32'h1, 32'h20, 32'h1, 32'h0F, 32'h0, 32'hF000, 32'hFFFF, 32'h0};
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            ALUControlE = op[i]; RD1_E = a[i]; RD2_E = b[i];
            step();
            n_cmp++; if (ALUResultM !== exp_res[i]) begin n_err++; $display("FAIL alu_%0d op=%b got %h want %h", i, op[i], ALUResultM, exp_res[i]); end
        end
        ALUControlE = 3'b000; RD1_E = 10; RD2_E = 100; ImmExtE = 5; ALUSrcE = 1;
        step();
        n_cmp++; if (ALUResultM !== 32'd15 || WriteDataM !== 32'd100) begin n_err++; $display("FAIL alu_imm got %h/%h want 0000000f/00000064", ALUResultM, WriteDataM); end
    endtask

    task automatic test_stall();
        idle_inputs();
        RD1_E = 32'h1000; RD2_E = 32'hCAFE; ImmExtE = 8; ALUSrcE = 1; MemWriteE = 1;
        InstrE = 32'h0000_2000; PCPlus4E = 32'h64;
        step();
        n_cmp++; if (ALUResultM !== 32'h1008 || WriteDataM !== 32'hCAFE || MemWriteM !== 1'b1 || funct3M !== 3'b010) begin
            n_err++; $display("FAIL store_cap got %h/%h mw=%b f3=%b want 00001008/0000cafe 1 010", ALUResultM, WriteDataM, MemWriteM, funct3M); end
        StallM = 1;
        for (int i = 0; i < 3; i++) begin
            RD1_E = 32'h2000 + i; RD2_E = 32'h1111 * (i + 1); MemWriteE = 0; RegWriteE = 1;
            RdE = 5'(7 + i); InstrE = 32'h0000_5000; PCPlus4E = 32'h80 + i;
            step();
            n_cmp++; if (ALUResultM !== 32'h1008 || WriteDataM !== 32'hCAFE || MemWriteM !== 1'b1 || RegWriteM !== 1'b0 || PCPlus4M !== 32'h64 || RdM !== 0) begin
                n_err++; $display("FAIL stall_hold_%0d got %h/%h mw=%b rw=%b pc4=%h rd=%0d want frozen", i, ALUResultM, WriteDataM, MemWriteM, RegWriteM, PCPlus4M, RdM); end
        end
        StallM = 0;
        step();
        n_cmp++; if (ALUResultM !== 32'h200A || WriteDataM !== 32'h3333 || RdM !== 5'd9 || RegWriteM !== 1'b1 || MemWriteM !== 1'b0 || funct3M !== 3'b101) begin
            n_err++; $display("FAIL stall_release got %h/%h rd=%0d rw=%b mw=%b f3=%b want 0000200a/00003333 9 1 0 101", ALUResultM, WriteDataM, RdM, RegWriteM, MemWriteM, funct3M); end
        StallM = 1;
        #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (ALUResultM !== 0 || WriteDataM !== 0 || PCPlus4M !== 0 || RegWriteM !== 0 || RdM !== 0 || funct3M !== 0) begin
            n_err++; $display("FAIL async_reset got %h/%h pc4=%h rw=%b rd=%0d f3=%b want all 0", ALUResultM, WriteDataM, PCPlus4M, RegWriteM, RdM, funct3M); end
        step();
        rst = 1'b1; StallM = 0;
        step();
        n_cmp++; if (ALUResultM !== 32'h200A || RdM !== 5'd9) begin n_err++; $display("FAIL reset_resume got %h rd=%0d want 0000200a 9", ALUResultM, RdM); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_forwarding();
        test_branches();
        test_jalr();
        test_alu_ops();
        test_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage RV32I pipeline; consumes the ID/EX register outputs of the decode stage.
- Applies forwarding selects from the hazard unit, runs the ALU, resolves branches and jumps (PCSrcE/PCTargetE back to fetch), and holds the EX/MEM pipeline register feeding the memory stage.
- EX/MEM register supports a hold (stall) for a waiting memory stage.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
RD1_E  in  32  rs1 operand from ID/EX
RD2_E  in  32  rs2 operand from ID/EX
ImmExtE  in  32  sign-extended immediate
PCE  in  32  instruction PC
PCPlus4E  in  32  PC+4
InstrE  in  32  instruction word; funct3 = InstrE[14:12]
RdE  in  5  destination register
RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE  in  1 each  decode control bits
ALUControlE  in  3  ALU operation
ResultSrcE  in  2  writeback select, passed through
ResultW  in  32  writeback-stage result for forwarding
ForwardAE, ForwardBE  in  2 each  00 = RD*_E, 01 = ResultW, 10 = ALUResultM, 11 = RD*_E
StallM  in  1  1 = hold the EX/MEM register
PCSrcE  out  1  redirect fetch (combinational)
PCTargetE  out  32  redirect target (combinational)
ALUResultM  out  32  registered ALU result
WriteDataM  out  32  registered forwarded rs2 (store data)
PCPlus4M  out  32  registered PC+4
RdM  out  5  registered destination
RegWriteM, MemWriteM  out  1 each  registered controls
ResultSrcM  out  2  registered
funct3M  out  3  registered funct3 (load/store width)

Behaviour:
- Operand muxes:
  - SrcAE = ForwardAE-selected value.
  - WriteDataE = ForwardBE-selected value.
  - SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
  - ALUResultM as a forwarding source is this block's own registered output.
- ALUControlE encoding:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor.
  - 101 slt (signed, result 0/1), 110 sll, 111 srl.
  - Shift amount = SrcBE[4:0]; add/sub wrap modulo 2^32.
- Branch compare uses SrcAE vs WriteDataE, independent of the ALU:
  - funct3 000 beq, 001 bne, 100 blt (signed), 101 bge (signed), 110 bltu, 111 bgeu.
  - funct3 010/011 → not taken.
- PCSrcE = JumpE | (BranchE & taken). Combinational, not gated by StallM.
- PCTargetE = jalrE ? ((SrcAE + ImmExtE) & 0xFFFFFFFE) : (PCE + ImmExtE).
- EX/MEM register:
  - Captures ALUResultE, WriteDataE, PCPlus4E, RdE, RegWriteE, MemWriteE, ResultSrcE and funct3 on every rising clk when StallM=0.
  - StallM=1: all M outputs hold their value.
  - Latency: 1 cycle from E inputs to M outputs.
- Reset: rst=0 asynchronously clears every M output to 0 (RegWriteM=0, MemWriteM=0: the stage is a bubble). Reset overrides StallM. Deasserting reset mid-stream resumes capture on the next edge.
- Flushing the stage is done upstream by zeroing the decode controls; this block adds no flush logic.
- No X propagation: ForwardxE=11 behaves as 00.

Test Plan:
- Reset: rst=0 with random inputs and clk toggling → all M outputs 0. Release, then add RD1=5, RD2=7, ALUControlE=000, ALUSrcE=0, RdE=3, RegWriteE=1 → next edge ALUResultM=12, RdM=3, RegWriteM=1.
- Forwarding: ALUResultM=0x10, ResultW=0x20, RD1=1, ForwardAE=10, ForwardBE=01, sub → ALUResultM becomes 0xFFFFFFF0. Repeat with ForwardAE=11 → uses RD1.
- Branches: SrcA=0xFFFFFFFF, SrcB=1, BranchE=1, PCE=0x100, Imm=0x20:
  - blt → PCSrcE=1, PCTargetE=0x120.
  - bltu → PCSrcE=0.
  - beq with equal operands → PCSrcE=1.
  - funct3=010 → PCSrcE=0.
- jalr: RD1=0x203, Imm=4, jalrE=1, JumpE=1, PCPlus4E=0x44, ResultSrcE=10 → PCTargetE=0x206, PCSrcE=1; next edge PCPlus4M=0x44, ResultSrcM=10.
- ALU ops: slt(-3, 2)=1; sll(1, 0x25)=0x20 (shamt 5); srl(0x80000000, 31)=1; xor(0xF0, 0xFF)=0x0F; add 0xFFFFFFFF+1=0.
- Stall: store with StallM=1 for 3 cycles while E inputs change → M outputs frozen. StallM=0 → captures current E inputs. Assert rst=0 during a stall → M outputs clear immediately, without waiting for a clock edge.
